usb4_sym_encoder: RTL and testbench

//  Multi-lane USB4 logical-layer symbol encoder. Collects per-lane byte streams into
//  Gen2 64b/66b or Gen3 128b/132b symbols with sync header, or passes bytes through (Gen4).

---
 rtl/usb4_enc_pkg.sv | 42 ++++
 rtl/usb4_lane_acc.sv | 65 ++++++
 rtl/usb4_sym_encoder.sv | 164 ++++++++++++++++
 tb/tb_usb4_sym_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_enc_pkg.sv
// USB4 symbol encoder shared definitions.
// Generation codes, sync headers and per-generation sizing helpers.
package usb4_enc_pkg;

   localparam logic [1:0] GEN4     = 2'd0;
   localparam logic [1:0] GEN3     = 2'd1;
   localparam logic [1:0] GEN2     = 2'd2;
   localparam logic [1:0] GEN_RSVD = 2'd3;

   localparam logic [3:0] D_SEL_TRANSPORT = 4'd8;
   localparam logic [3:0] D_SEL_IDLE      = 4'd9;

   localparam logic [3:0] SH_TRANSPORT_G3 = 4'b1010;
   localparam logic [3:0] SH_OS_G3        = 4'b0101;
   localparam logic [1:0] SH_TRANSPORT_G2 = 2'b10;
   localparam logic [1:0] SH_OS_G2        = 2'b01;

   localparam int MAX_BYTES = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_STALL
   } enc_state_e;

   function automatic logic [4:0] sym_bytes(input logic [1:0] gen);
      case (gen)
         GEN3:    return 5'd16;
         GEN2:    return 5'd8;
         default: return 5'd1;
      endcase
   endfunction

   function automatic logic [2:0] hdr_w(input logic [1:0] gen);
      case (gen)
         GEN3:    return 3'd4;
         GEN2:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/usb4_lane_acc.sv
// Per-lane byte accumulator and symbol packer.
// Bytes land at their symbol slot; packing masks slots beyond the symbol size.
module usb4_lane_acc
   import usb4_enc_pkg::*;
#(
   parameter int SYM_W = 132
) (
   input  logic             enc_clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [3:0]       idx,
   input  logic [7:0]       byte_in,
   input  logic [1:0]       gen,
   input  logic             hdr_trans,
   output logic [SYM_W-1:0] sym
);

   logic [MAX_BYTES*8-1:0] data_q;
   logic [MAX_BYTES*8-1:0] data_d;
   logic [MAX_BYTES*8-1:0] bytes_v;
   logic [4:0]             nb;
   int                     hw;

   // Next byte store: write accepted byte into its slot, wipe on clear.
   always_comb begin
      data_d = data_q;
      if (clr) begin
         data_d = '0;
      end else if (wr_en) begin
         data_d[{idx, 3'b000} +: 8] = byte_in;
      end
   end

   // Byte store register.
   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Pack header and bytes, bypassing the byte arriving this cycle.
   always_comb begin
      bytes_v = data_q;
      if (wr_en) begin
         bytes_v[{idx, 3'b000} +: 8] = byte_in;
      end
      nb  = sym_bytes(gen);
      hw  = int'(hdr_w(gen));
      sym = '0;
      case (gen)
         GEN3:    sym[3:0] = hdr_trans ? SH_TRANSPORT_G3 : SH_OS_G3;
         GEN2:    sym[1:0] = hdr_trans ? SH_TRANSPORT_G2 : SH_OS_G2;
         default: ;
      endcase
      for (int n = 0; n < MAX_BYTES; n++) begin
         if (5'(n) < nb) begin
            sym[hw + 8*n +: 8] = bytes_v[8*n +: 8];
         end
      end
   end

endmodule

// File: rtl/usb4_sym_encoder.sv
// Multi-lane USB4 symbol encoder with valid/ready and output skid register.
// Owns the fill FSM, byte counter, class latch and output register.
module usb4_sym_encoder
   import usb4_enc_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int SYM_W     = 132
) (
   input  logic                       enc_clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [1:0]                 gen_speed,
   input  logic [3:0]                 d_sel,
   input  logic                       in_valid,
   input  logic [8*NUM_LANES-1:0]     lane_tx,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SYM_W*NUM_LANES-1:0] lane_tx_enc,
   output logic                       enable_ser,
   output logic                       new_sym,
   output logic                       class_err
);

   enc_state_e                 state_q, state_d, eff_state;
   logic [3:0]                 cnt_q, cnt_d, eff_cnt;
   logic                       cls_q, cls_d;
   logic [1:0]                 gen_q, gen_d;
   logic [SYM_W*NUM_LANES-1:0] out_q, out_d, sym_all;
   logic                       ov_q, ov_d;
   logic                       ser_q, ser_d;
   logic                       ns_q, ns_d;
   logic                       cerr_q, cerr_d;
   logic                       gen_chg, d_trans, acc, last, load;
   logic                       hdr_trans, clr;

   assign clr = ~enable;

   // Handshake decode; a generation switch mid-symbol restarts from IDLE.
   always_comb begin
      gen_chg   = (gen_speed != gen_q) && (state_q != S_IDLE);
      eff_state = gen_chg ? S_IDLE : state_q;
      eff_cnt   = gen_chg ? 4'd0 : cnt_q;
      in_ready  = rst & enable & (gen_speed != GEN_RSVD)
                & (state_q != S_STALL);
      d_trans   = (d_sel == D_SEL_TRANSPORT);
      acc       = in_valid & in_ready & (d_sel != D_SEL_IDLE);
      last      = acc & ({1'b0, eff_cnt} == sym_bytes(gen_speed) - 5'd1);
      hdr_trans = (acc && eff_cnt == 4'd0) ? d_trans : cls_q;
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      usb4_lane_acc #(
         .SYM_W(SYM_W)
      ) u_acc (
         .enc_clk  (enc_clk),
         .rst      (rst),
         .clr      (clr),
         .wr_en    (acc),
         .idx      (eff_cnt),
         .byte_in  (lane_tx[8*k +: 8]),
         .gen      (gen_speed),
         .hdr_trans(hdr_trans),
         .sym      (sym_all[SYM_W*k +: SYM_W])
      );
   end

   // Next state, counter, class latch and output register load.
   always_comb begin
      state_d = eff_state;
      cnt_d   = eff_cnt;
      cls_d   = cls_q;
      gen_d   = gen_speed;
      out_d   = out_q;
      ov_d    = ov_q;
      ser_d   = ser_q;
      ns_d    = 1'b0;
      cerr_d  = 1'b0;
      load    = 1'b0;
      if (ov_q && out_ready) begin
         ov_d = 1'b0;
      end
      if (acc && eff_cnt == 4'd0) begin
         cls_d = d_trans;
      end
      if (acc && eff_cnt != 4'd0 && d_trans != cls_q) begin
         cerr_d = 1'b1;
      end
      unique case (eff_state)
         S_IDLE, S_FILL: begin
            if (acc) begin
               if (last) begin
                  if (!ov_q || out_ready) begin
                     load    = 1'b1;
                     state_d = S_IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     state_d = S_STALL;
                  end
               end else begin
                  state_d = S_FILL;
                  cnt_d   = eff_cnt + 4'd1;
               end
            end
         end
         S_STALL: begin
            if (out_ready) begin
               load    = 1'b1;
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         out_d = sym_all;
         ov_d  = 1'b1;
         ns_d  = 1'b1;
         ser_d = 1'b1;
      end
      if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = 4'd0;
         cls_d   = 1'b0;
         out_d   = '0;
         ov_d    = 1'b0;
         ser_d   = 1'b0;
         ns_d    = 1'b0;
         cerr_d  = 1'b0;
      end
   end

   // Control and output registers.
   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         cls_q   <= 1'b0;
         gen_q   <= GEN4;
         out_q   <= '0;
         ov_q    <= 1'b0;
         ser_q   <= 1'b0;
         ns_q    <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cls_q   <= cls_d;
         gen_q   <= gen_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         ser_q   <= ser_d;
         ns_q    <= ns_d;
         cerr_q  <= cerr_d;
      end
   end

   assign out_valid   = ov_q;
   assign lane_tx_enc = out_q;
   assign enable_ser  = ser_q;
   assign new_sym     = ns_q;
   assign class_err   = cerr_q;

endmodule

// File: tb/tb_usb4_sym_encoder.sv
// Scoreboard bench for usb4_sym_encoder.
// Directed vectors push expected symbols; a monitor pops on each handshake.
module tb_usb4_sym_encoder;

   logic         enc_clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [1:0]   gen_speed;
   logic [3:0]   d_sel;
   logic         in_valid;
   logic [15:0]  lane_tx;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [263:0] lane_tx_enc;
   logic         enable_ser;
   logic         new_sym;
   logic         class_err;

   int n_chk  = 0;
   int n_pass = 0;
   int nsym   = 0;
   logic [263:0] sb[$];

   always #5 enc_clk = ~enc_clk;

   usb4_sym_encoder #(
      .NUM_LANES(2),
      .SYM_W    (132)
   ) dut (
      .enc_clk    (enc_clk),
      .rst        (rst),
      .enable     (enable),
      .gen_speed  (gen_speed),
      .d_sel      (d_sel),
      .in_valid   (in_valid),
      .lane_tx    (lane_tx),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .lane_tx_enc(lane_tx_enc),
      .enable_ser (enable_ser),
      .new_sym    (new_sym),
      .class_err  (class_err)
   );

   task automatic chk(input string nm, input logic [263:0] act,
                      input logic [263:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [131:0] pk(input logic [1:0] g, input bit tr,
                                       input logic [127:0] d);
      case (g)
         2'd1:    pk = {d, tr ? 4'b1010 : 4'b0101};
         2'd2:    pk = {66'b0, d[63:0], tr ? 2'b10 : 2'b01};
         default: pk = {124'b0, d[7:0]};
      endcase
   endfunction

   task automatic sym_exp(input logic [1:0] g, input bit tr,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input int n);
      logic [127:0] d0 = '0;
      logic [127:0] d1 = '0;
      for (int i = 0; i < n; i++) begin
         d0[8*i +: 8] = b0 + 8'(i);
         d1[8*i +: 8] = b1 + 8'(i);
      end
      sb.push_back({pk(g, tr, d1), pk(g, tr, d0)});
   endtask

   task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [3:0] ds);
      bit ok = 1'b0;
      in_valid = 1'b1;
      lane_tx  = {b1, b0};
      d_sel    = ds;
      for (int t = 0; t < 200; t++) begin
         @(negedge enc_clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge enc_clk);
      #1;
   endtask

   task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1,
                           input int n, input logic [3:0] ds);
      for (int i = 0; i < n; i++) send(b0 + 8'(i), b1 + 8'(i), ds);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge enc_clk);
      #1;
   endtask

   // Monitor: compare every consumed symbol against the scoreboard.
   initial begin
      forever begin
         @(negedge enc_clk);
         if (new_sym === 1'b1) nsym++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_symbol: got %0h expected none",
                        lane_tx_enc);
            end else begin
               chk("symbol", lane_tx_enc, sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      gen_speed = 2'd1;
      d_sel     = 4'd8;
      in_valid  = 1'b0;
      lane_tx   = '0;
      out_ready = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_enc", lane_tx_enc, 0);
      chk("rst_enable_ser", enable_ser, 0);
      @(posedge enc_clk);
      #1 rst = 1'b1;
      enable = 1'b1;
      idle(2);

      // Gen3 transport symbol, latency and single new_sym.
      sym_exp(2'd1, 1'b1, 8'h00, 8'h80, 16);
      send_seq(8'h00, 8'h80, 15, 4'd8);
      chk("pre_last_valid", out_valid, 0);
      send(8'h0F, 8'h8F, 4'd8);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_new_sym", new_sym, 1);
      idle(3);
      chk("new_sym_once", nsym, 1);
      chk("enable_ser_set", enable_ser, 1);
      chk("out_valid_drop", out_valid, 0);

      // Gen2 ordered set.
      gen_speed = 2'd2;
      sym_exp(2'd2, 1'b0, 8'hA0, 8'hB0, 8);
      send_seq(8'hA0, 8'hB0, 8, 4'd2);
      idle(3);

      // Gen3 back-to-back with stall.
      gen_speed = 2'd1;
      out_ready = 1'b0;
      sym_exp(2'd1, 1'b1, 8'h10, 8'h90, 16);
      sym_exp(2'd1, 1'b1, 8'h20, 8'hA0, 16);
      sym_exp(2'd1, 1'b1, 8'h30, 8'hB0, 16);
      send_seq(8'h10, 8'h90, 16, 4'd8);
      send_seq(8'h20, 8'hA0, 16, 4'd8);
      in_valid = 1'b0;
      @(negedge enc_clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      fork
         send_seq(8'h30, 8'hB0, 16, 4'd8);
         begin
            repeat (4) @(posedge enc_clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(4);
      chk("new_sym_count", nsym, 5);

      // Class change mid-symbol, idle byte ignored.
      for (int i = 0; i < 16; i++) begin
         send(8'h40 + 8'(i), 8'hC0 + 8'(i), (i == 5) ? 4'd2 : 4'd8);
         if (i == 5) chk("class_err_pulse", class_err, 1);
         if (i == 6) chk("class_err_clear", class_err, 0);
         if (i == 9) begin
            send(8'hEE, 8'hEE, 4'd9);
            chk("idle_no_err", class_err, 0);
         end
      end
      sym_exp(2'd1, 1'b1, 8'h40, 8'hC0, 16);
      idle(3);

      // Gen2 -> Gen3 switch drops partial symbol.
      gen_speed = 2'd2;
      send_seq(8'h11, 8'h21, 3, 4'd2);
      in_valid = 1'b0;
      gen_speed = 2'd1;
      idle(2);
      sym_exp(2'd1, 1'b0, 8'h50, 8'hD0, 16);
      send_seq(8'h50, 8'hD0, 16, 4'd2);
      idle(3);

      // Gen4 byte pass-through.
      gen_speed = 2'd0;
      for (int i = 0; i < 3; i++) begin
         sym_exp(2'd0, 1'b1, 8'h61 + 8'(i), 8'hE1 + 8'(i), 1);
         send(8'h61 + 8'(i), 8'hE1 + 8'(i), 4'd8);
      end
      idle(3);
      chk("new_sym_total", nsym, 10);

      // Reset mid-FILL, then a clean symbol.
      gen_speed = 2'd1;
      send_seq(8'h70, 8'hF0, 5, 4'd8);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rstfill_in_ready", in_ready, 0);
      chk("rstfill_enable_ser", enable_ser, 0);
      @(posedge enc_clk);
      #1 rst = 1'b1;
      sym_exp(2'd1, 1'b1, 8'h80, 8'h00, 16);
      send_seq(8'h80, 8'h00, 16, 4'd8);
      idle(3);

      // Reset mid-STALL.
      out_ready = 1'b0;
      send_seq(8'h01, 8'h02, 32, 4'd8);
      in_valid = 1'b0;
      @(negedge enc_clk);
      chk("stall2_in_ready", in_ready, 0);
      #1 rst = 1'b0;
      #1;
      chk("rststall_valid", out_valid, 0);
      chk("rststall_enc", lane_tx_enc, 0);
      chk("rststall_ser", enable_ser, 0);
      @(posedge enc_clk);
      #1 rst = 1'b1;

      // Enable low clears on next edge.
      send_seq(8'h05, 8'h06, 16, 4'd8);
      in_valid = 1'b0;
      @(negedge enc_clk);
      chk("en_valid_before", out_valid, 1);
      #1 enable = 1'b0;
      #1;
      chk("en_in_ready", in_ready, 0);
      chk("en_valid_hold", out_valid, 1);
      @(posedge enc_clk);
      #1;
      chk("en_valid_clr", out_valid, 0);
      chk("en_ser_clr", enable_ser, 0);
      chk("en_enc_clr", lane_tx_enc, 0);
      enable = 1'b1;
      out_ready = 1'b1;
      idle(3);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
